// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: grants one requester per cycle, forwards legal
// accesses with byte lanes, routes the registered response back one cycle later.
// Define ARB_ROUND_ROBIN_EN for alternating priority; the default build uses fixed priority (port 0 wins).
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dbg_last_gnt_o
);

  // Handshake: a transaction is accepted in any cycle where req and gnt are both
  // high; its response (rvalid) follows exactly one cycle later on the same port.

  logic              last_gnt_q, last_gnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_port_q, resp_port_d;
  logic              resp_we_q, resp_we_d;
  logic              resp_err_q, resp_err_d;

  logic              prefer_p1;
  logic              accept;
  logic              sel_p1;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        offset;
  logic              illegal;
  logic              forward;
  logic              rv;
  logic [DATA_W-1:0] resp_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  assign prefer_p1 = ~last_gnt_q;
`else
  assign prefer_p1 = 1'b0;
`endif

  always_comb begin
    p0_gnt    = ~rst & p0_req & ~(p1_req & prefer_p1);
    p1_gnt    = ~rst & p1_req & (~p0_req | prefer_p1);
    accept    = p0_gnt | p1_gnt;
    sel_p1    = p1_gnt;
    sel_we    = sel_p1 ? p1_we    : p0_we;
    sel_size  = sel_p1 ? p1_size  : p0_size;
    sel_addr  = sel_p1 ? p1_addr  : p0_addr;
    sel_wdata = sel_p1 ? p1_wdata : p0_wdata;
    offset    = sel_addr[1:0];
    illegal   = (sel_size == 2'b11) ||
                ((sel_size == 2'b01) && offset[0]) ||
                ((sel_size == 2'b10) && (offset != 2'b00));
    forward   = accept & ~illegal;
  end

  // Memory side is all-zero unless a legal access is accepted this cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (forward) begin
      mem_en    = 1'b1;
      mem_we    = sel_we;
      mem_addr  = {sel_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = sel_wdata << {offset, 3'b000};
      case (sel_size)
        2'b00:   mem_be = 4'b0001 << offset;
        2'b01:   mem_be = 4'b0011 << offset;
        default: mem_be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    resp_valid_d = accept;
    resp_port_d  = resp_port_q;
    resp_we_d    = resp_we_q;
    resp_err_d   = resp_err_q;
    last_gnt_d   = last_gnt_q;
    if (accept) begin
      resp_port_d = sel_p1;
      resp_we_d   = sel_we;
      resp_err_d  = illegal;
      last_gnt_d  = sel_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      last_gnt_q   <= 1'b1;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_we_q    <= resp_we_d;
      resp_err_q   <= resp_err_d;
      last_gnt_q   <= last_gnt_d;
    end
  end

  // Masking with rst drops a response whose acceptance was followed by reset.
  always_comb begin
    rv         = resp_valid_q & ~rst;
    resp_rdata = (rv & ~resp_we_q & ~resp_err_q) ? mem_rdata : '0;
    p0_rvalid  = rv & ~resp_port_q;
    p1_rvalid  = rv &  resp_port_q;
    p0_rdata   = p0_rvalid ? resp_rdata : '0;
    p1_rdata   = p1_rvalid ? resp_rdata : '0;
    p0_err     = p0_rvalid & resp_err_q;
    p1_err     = p1_rvalid & resp_err_q;
  end

  assign dbg_last_gnt_o = last_gnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter with a small word memory model and a
// response scoreboard; honours ARB_ROUND_ROBIN_EN for the contention vectors.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [1:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        dbg_last_gnt;

  logic [31:0] mem_words [0:15];
  logic        mem_load;
  logic [33:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_last_gnt_o(dbg_last_gnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: one-cycle read latency, byte-lane writes
  always @(posedge clk) begin
    if (mem_load) begin
      for (int w = 0; w < 16; w++) mem_words[w] <= 32'h0;
      mem_words[0] <= 32'h11111111;
      mem_words[1] <= 32'h22222222;
      mem_words[2] <= 32'hDEADBEEF;
      mem_rdata    <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem_words[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem_words[mem_addr[5:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic clear_reqs();
    p0_req = 1'b0; p0_we = 1'b0; p0_size = 2'b00; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_size = 2'b00; p1_addr = 32'h0; p1_wdata = 32'h0;
  endtask

  task automatic drive_port(input bit port, input logic we, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] wd);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_size = sz; p1_addr = addr; p1_wdata = wd;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_size = sz; p0_addr = addr; p0_wdata = wd;
    end
  endtask

  task automatic check_accept(input bit port, input logic we, input logic [31:0] addr,
                              input logic exp_en, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd);
    chk("p0_gnt", 32'(p0_gnt), 32'(!port));
    chk("p1_gnt", 32'(p1_gnt), 32'(port));
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    chk("mem_we", 32'(mem_we), 32'(exp_en & we));
    chk("mem_be", 32'(mem_be), 32'(exp_be));
    chk("mem_addr", mem_addr, exp_en ? (addr & 32'hFFFF_FFFC) : 32'h0);
    chk("mem_wdata", mem_wdata, exp_en ? exp_wd : 32'h0);
  endtask

  task automatic issue(input bit port, input logic we, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_en, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input logic exp_err, input logic [31:0] exp_rd);
    @(posedge clk); #1;
    clear_reqs();
    drive_port(port, we, sz, addr, wd);
    #1;
    check_accept(port, we, addr, exp_en, exp_be, exp_wd);
    exp_q.push_back({port, exp_err, exp_rd});
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    clear_reqs();
    #1;
    chk("idle_gnt", 32'({p1_gnt, p0_gnt}), 32'h0);
    chk("idle_mem_en", 32'(mem_en), 32'h0);
    chk("idle_mem_addr", mem_addr, 32'h0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [33:0] e;
    if (p0_rvalid || p1_rvalid) begin
      if (p0_rvalid && p1_rvalid) begin
        n_tests++; n_fail++;
        $display("FAIL resp_both: got rvalid=11 expected one port");
      end else if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL resp_unexpected: got rvalid p0=%b p1=%b expected none", p0_rvalid, p1_rvalid);
      end else begin
        e = exp_q.pop_front();
        chk("resp_port", 32'(p1_rvalid), 32'(e[33]));
        chk("resp_err", 32'(p1_rvalid ? p1_err : p0_err), 32'(e[32]));
        chk("resp_rdata", p1_rvalid ? p1_rdata : p0_rdata, e[31:0]);
        chk("resp_other_quiet", p1_rvalid ? (p0_rdata | 32'(p0_err)) : (p1_rdata | 32'(p1_err)), 32'h0);
      end
    end else begin
      chk("quiet_outputs", p0_rdata | p1_rdata | 32'({p0_err, p1_err}), 32'h0);
    end
  end

  initial begin
    bit g1;
    clear_reqs();
    rst = 1'b1;
    mem_load = 1'b1;
    // reset holds everything low even with a live request
    drive_port(1'b0, 1'b0, 2'b10, 32'h8, 32'h0);
    @(posedge clk); #1;
    chk("rst_gnt", 32'({p1_gnt, p0_gnt}), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_last_gnt", 32'(dbg_last_gnt), 32'h1);
    rst = 1'b0;
    mem_load = 1'b0;
    clear_reqs();

    // both requesters held four cycles: p0 word 0x0 and p1 word 0x8
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      clear_reqs();
      drive_port(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
      drive_port(1'b1, 1'b0, 2'b10, 32'h8, 32'h0);
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      g1 = (i % 2) == 1;
`else
      g1 = 1'b0;
`endif
      chk("cont_p0_gnt", 32'(p0_gnt), 32'(!g1));
      chk("cont_p1_gnt", 32'(p1_gnt), 32'(g1));
      chk("cont_mem_addr", mem_addr, g1 ? 32'h8 : 32'h0);
      exp_q.push_back({g1, 1'b0, g1 ? 32'hDEADBEEF : 32'h11111111});
    end
    go_idle();
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    chk("cont_last_gnt", 32'(dbg_last_gnt), 32'h1);
`else
    chk("cont_last_gnt", 32'(dbg_last_gnt), 32'h0);
`endif

    issue(1'b0, 1'b0, 2'b10, 32'h8, 32'h0, 1'b1, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF);
    issue(1'b1, 1'b1, 2'b00, 32'h7, 32'h000000AB, 1'b1, 4'b1000, 32'hAB000000, 1'b0, 32'h0);
    issue(1'b0, 1'b0, 2'b10, 32'h4, 32'h0, 1'b1, 4'b1111, 32'h0, 1'b0, 32'hAB222222);
    issue(1'b0, 1'b0, 2'b01, 32'h3, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 1'b0, 2'b11, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 1'b1, 2'b10, 32'h2, 32'hFFFFFFFF, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 1'b1, 2'b01, 32'h2, 32'h00001234, 1'b1, 4'b1100, 32'h12340000, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 2'b01, 32'h2, 32'h0, 1'b1, 4'b1100, 32'h0, 1'b0, 32'h12341111);
    issue(1'b0, 1'b0, 2'b00, 32'h5, 32'h0, 1'b1, 4'b0010, 32'h0, 1'b0, 32'hAB222222);

    // back-to-back loads, then reset kills the second response
    issue(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h12341111);
    @(posedge clk); #1;
    clear_reqs();
    drive_port(1'b1, 1'b0, 2'b10, 32'h4, 32'h0);
    #1;
    check_accept(1'b1, 1'b0, 32'h4, 1'b1, 4'b1111, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_reqs();
    #1;
    chk("rst_kill_p1_rvalid", 32'(p1_rvalid), 32'h0);
    @(posedge clk); #1;
    chk("rst_last_gnt2", 32'(dbg_last_gnt), 32'h1);
    // first cycle out of reset: a lone p1 request is granted immediately
    rst = 1'b0;
    drive_port(1'b1, 1'b0, 2'b10, 32'h8, 32'h0);
    #1;
    check_accept(1'b1, 1'b0, 32'h8, 1'b1, 4'b1111, 32'h0);
    exp_q.push_back({1'b1, 1'b0, 32'hDEADBEEF});
    go_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("resp_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
